// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encoding
// and wait-state counter sizing.
package arm_pipe_pkg;

  localparam int WAIT_W       = 4;
  localparam int MEM_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/wait_state_counter.sv
// Down-counter that times the SRAM access: loaded at request, decremented
// while the access is outstanding, flags zero when the last wait cycle is due.
module wait_state_counter
  import arm_pipe_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority; decrement stops at zero so the counter never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != 0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: freezes the pipe for SRAM accesses, bubbles
// for data hazards, flushes on taken branches. Optional performance
// counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 4,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hazard_detected,
  input  logic              branch_taken,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              perf_clr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_exe_en,
  output logic              exe_mem_en,
  output logic              if_id_flush,
  output logic              id_exe_flush,
  output logic              mem_wb_bubble,
  output logic              mem_access_done,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] mem_stall_cnt
);

  localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(MEM_WAIT_CYCLES - 1);

  pipe_state_e state, state_nxt;
  logic        mem_req;
  logic        mem_freeze;
  logic        wait_zero;

  assign mem_req = mem_r_en | mem_w_en;

  wait_state_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == RUN && mem_req),
    .load_val (LOAD_VAL),
    .dec      (state == MEM_BUSY),
    .zero     (wait_zero)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // next state and stage control decode; freeze beats branch beats hazard
  always_comb begin
    state_nxt       = state;
    mem_freeze      = 1'b0;
    pc_en           = 1'b1;
    if_id_en        = 1'b1;
    id_exe_en       = 1'b1;
    exe_mem_en      = 1'b1;
    if_id_flush     = 1'b0;
    id_exe_flush    = 1'b0;
    mem_wb_bubble   = 1'b0;
    mem_access_done = 1'b0;

    case (state)
      RUN: begin
        if (mem_req) begin
          state_nxt  = MEM_BUSY;
          mem_freeze = 1'b1;
        end
      end
      MEM_BUSY: begin
        mem_freeze = 1'b1;
        if (wait_zero) state_nxt = MEM_DONE;
      end
      MEM_DONE: begin
        // a request seen here is picked up next cycle in RUN
        state_nxt       = RUN;
        mem_access_done = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    if (mem_freeze) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_exe_en     = 1'b0;
      exe_mem_en    = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (hazard_detected) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // saturating event counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      flush_cnt     <= '0;
      mem_stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt     <= '0;
      flush_cnt     <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + PERF_W'(1);
      if ((if_id_flush || id_exe_flush) && flush_cnt != '1)
        flush_cnt <= flush_cnt + PERF_W'(1);
      if (mem_freeze && mem_stall_cnt != '1)
        mem_stall_cnt <= mem_stall_cnt + PERF_W'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf   = perf_clr;
  assign stall_cnt     = '0;
  assign flush_cnt     = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (4 and 1 wait cycles)
// share stimulus; a cycle-level model tracks remaining freeze cycles per
// instance and derives expected controls and counters from the rules.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_detected = 1'b0, branch_taken = 1'b0;
  logic mem_r_en = 1'b0, mem_w_en = 1'b0, perf_clr = 1'b0;

  // {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_flush, mem_wb_bubble, mem_access_done}
  wire [7:0]  ctl4, ctl1;
  wire [31:0] sc4, fc4, mc4, sc1, fc1, mc1;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_WAIT_CYCLES(4), .PERF_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .perf_clr(perf_clr),
    .pc_en(ctl4[7]), .if_id_en(ctl4[6]), .id_exe_en(ctl4[5]), .exe_mem_en(ctl4[4]),
    .if_id_flush(ctl4[3]), .id_exe_flush(ctl4[2]), .mem_wb_bubble(ctl4[1]),
    .mem_access_done(ctl4[0]),
    .stall_cnt(sc4), .flush_cnt(fc4), .mem_stall_cnt(mc4)
  );

  pipeline_stall_controller #(.MEM_WAIT_CYCLES(1), .PERF_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .perf_clr(perf_clr),
    .pc_en(ctl1[7]), .if_id_en(ctl1[6]), .id_exe_en(ctl1[5]), .exe_mem_en(ctl1[4]),
    .if_id_flush(ctl1[3]), .id_exe_flush(ctl1[2]), .mem_wb_bubble(ctl1[1]),
    .mem_access_done(ctl1[0]),
    .stall_cnt(sc1), .flush_cnt(fc1), .mem_stall_cnt(mc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam longint SAT = 64'hFFFF_FFFF;
  int     wcyc[2] = '{4, 1};
  int     frz_left[2];   // freeze cycles still owed after the current one
  bit     done_now[2];   // current cycle is the access-complete cycle
  longint m_stall[2], m_flush[2], m_mstall[2];

  function automatic logic [7:0] exp_ctl(input int i);
    bit req = mem_r_en | mem_w_en;
    bit frz = !done_now[i] && (frz_left[i] > 0 || req);
    bit d   = done_now[i];
    if (frz)                  return 8'b0000_0010;
    else if (branch_taken)    return {7'b1111_110, d};
    else if (hazard_detected) return {7'b0011_010, d};
    else                      return {7'b1111_000, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      frz_left[i] = 0; done_now[i] = 0;
      m_stall[i] = 0; m_flush[i] = 0; m_mstall[i] = 0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e = exp_ctl(i);
      if (perf_clr) begin
        m_stall[i] = 0; m_flush[i] = 0; m_mstall[i] = 0;
      end else begin
        if (!e[7] && m_stall[i] < SAT)          m_stall[i]++;
        if ((e[3] | e[2]) && m_flush[i] < SAT)  m_flush[i]++;
        if (e[1] && m_mstall[i] < SAT)          m_mstall[i]++;
      end
      if (done_now[i]) done_now[i] = 0;
      else if (frz_left[i] > 0) begin
        frz_left[i]--;
        if (frz_left[i] == 0) done_now[i] = 1;
      end else if (mem_r_en | mem_w_en) frz_left[i] = wcyc[i];
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/ctl4"}, 64'(ctl4), 64'(exp_ctl(0)));
    chk({tag, "/ctl1"}, 64'(ctl1), 64'(exp_ctl(1)));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, "/stall4"}, 64'(sc4), 64'(m_stall[0]));
    chk({tag, "/flush4"}, 64'(fc4), 64'(m_flush[0]));
    chk({tag, "/mstall4"}, 64'(mc4), 64'(m_mstall[0]));
    chk({tag, "/stall1"}, 64'(sc1), 64'(m_stall[1]));
    chk({tag, "/flush1"}, 64'(fc1), 64'(m_flush[1]));
    chk({tag, "/mstall1"}, 64'(mc1), 64'(m_mstall[1]));
`else
    chk({tag, "/perf_off"}, {sc4 | fc4 | mc4, sc1 | fc1 | mc1}, 64'd0);
`endif
  endtask

  // drive inputs, check on the falling edge, advance the model at the rising edge
  task automatic step(input bit h, input bit b, input bit r, input bit w, input bit c,
                      input string tag);
    hazard_detected = h; branch_taken = b; mem_r_en = r; mem_w_en = w; perf_clr = c;
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // asynchronous reset pulse placed between edges, then realign to the clock
  task automatic async_reset(input string tag);
    hazard_detected = 0; branch_taken = 0; mem_r_en = 0; mem_w_en = 0; perf_clr = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  int bub4, bub1, done_at;

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    model_clock();
    #1;

    // load held over the whole access: 5 frozen cycles, done on the 6th
    bub4 = 0; done_at = -1;
    for (int k = 0; k < 8; k++) begin
      hazard_detected = 0; branch_taken = 0; mem_r_en = (k < 6); mem_w_en = 0; perf_clr = 0;
      @(negedge clk);
      if (ctl4[1]) bub4++;
      if (ctl4[0] && done_at < 0) done_at = k;
      check_all("held_load");
      @(posedge clk);
      model_clock();
      #1;
    end
    chk("held_load/frz_len4", 64'(bub4), 64'd5);
    chk("held_load/done_cyc4", 64'(done_at), 64'd5);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, "idle");

    // single-cycle store: 5 frozen cycles at W=4, 2 at W=1
`ifdef PIPE_PERF_CNT_EN
    step(0, 0, 0, 0, 1, "clr0");
`endif
    bub4 = 0; bub1 = 0;
    for (int k = 0; k < 8; k++) begin
      hazard_detected = 0; branch_taken = 0; mem_r_en = 0; mem_w_en = (k == 0); perf_clr = 0;
      @(negedge clk);
      if (ctl4[1]) bub4++;
      if (ctl1[1]) bub1++;
      check_all("pulse_store");
      @(posedge clk);
      model_clock();
      #1;
    end
    chk("pulse_store/frz_len4", 64'(bub4), 64'd5);
    chk("pulse_store/frz_len1", 64'(bub1), 64'd2);
`ifdef PIPE_PERF_CNT_EN
    chk("pulse_store/mstall4", 64'(mc4), 64'd5);
    chk("pulse_store/stall4", 64'(sc4), 64'd5);
    step(0, 0, 0, 0, 1, "perf_clr");
    chk("perf_clr/zero4", 64'(sc4 | fc4 | mc4), 64'd0);
`endif

    // hazard alone, then branch with hazard
    step(1, 0, 0, 0, 0, "hazard");
    step(0, 0, 0, 0, 0, "after_hazard");
    step(1, 1, 0, 0, 0, "br_hazard");
    step(0, 0, 0, 0, 0, "after_br");

    // branch held during the access: flush only once the access completes
    step(0, 0, 1, 0, 0, "br_busy_req");
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0, "br_busy");
    step(0, 0, 0, 0, 0, "br_busy_end");

    // reset while the W=4 access has counter 2 left
    step(0, 0, 1, 0, 0, "rst_mid_req");
    step(0, 0, 0, 0, 0, "rst_mid_busy");
    check_all("rst_mid_pre");
    async_reset("rst_mid");
    step(0, 0, 0, 0, 0, "rst_mid_after");

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 40) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
